// File: rtl/rtc_time_keeper.sv
// 24 h wall-clock keeper (hours/minutes/seconds) with a two-button set sequence.
// Optional field blink request is built only when RTC_BLINK_EN is defined.
module rtc_time_keeper #(
    parameter int CLK_FREQ_HZ = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       setting_hours,
    output logic       setting_minutes,
    output logic       blink
);

    localparam int PW = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PW-1:0] PRE_TC = PW'(CLK_FREQ_HZ - 1);

    typedef enum logic [1:0] {
        ST_RUN         = 2'b00,
        ST_SET_HOURS   = 2'b01,
        ST_SET_MINUTES = 2'b10
    } state_t;

    state_t        state_r, state_next_s;
    logic [PW-1:0] prescaler_r, prescaler_next_s;
    logic [4:0]    hours_r, hours_next_s;
    logic [5:0]    minutes_r, minutes_next_s;
    logic [5:0]    seconds_r, seconds_next_s;
    logic          btn_mode_q_r, btn_inc_q_r;
    logic          setting_hours_r, setting_minutes_r;
    logic          mode_rise_s, inc_rise_s, tick_s;

    function automatic logic [5:0] inc_mod60(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] inc_mod24(input logic [4:0] v);
        return (v == 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    assign mode_rise_s = btn_mode & ~btn_mode_q_r;
    assign inc_rise_s  = btn_inc & ~btn_inc_q_r;
    assign tick_s      = (state_r == ST_RUN) && (prescaler_r == PRE_TC);

    // Next-state, time-field and prescaler update; mode edge has priority over inc edge.
    always_comb begin
        state_next_s     = state_r;
        prescaler_next_s = prescaler_r;
        hours_next_s     = hours_r;
        minutes_next_s   = minutes_r;
        seconds_next_s   = seconds_r;
        case (state_r)
            ST_RUN: begin
                if (tick_s) begin
                    prescaler_next_s = {PW{1'b0}};
                    seconds_next_s   = inc_mod60(seconds_r);
                    if (seconds_r == 6'd59) begin
                        minutes_next_s = inc_mod60(minutes_r);
                        if (minutes_r == 6'd59) begin
                            hours_next_s = inc_mod24(hours_r);
                        end else begin
                            hours_next_s = hours_r;
                        end
                    end else begin
                        minutes_next_s = minutes_r;
                    end
                end else begin
                    prescaler_next_s = prescaler_r + {{(PW-1){1'b0}}, 1'b1};
                end
                if (mode_rise_s) begin
                    state_next_s = ST_SET_HOURS;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_SET_HOURS: begin
                if (mode_rise_s) begin
                    state_next_s = ST_SET_MINUTES;
                end else if (inc_rise_s) begin
                    hours_next_s = inc_mod24(hours_r);
                end else begin
                    state_next_s = ST_SET_HOURS;
                end
            end
            ST_SET_MINUTES: begin
                if (mode_rise_s) begin
                    state_next_s     = ST_RUN;
                    seconds_next_s   = 6'd0;
                    prescaler_next_s = {PW{1'b0}};
                end else if (inc_rise_s) begin
                    minutes_next_s = inc_mod60(minutes_r);
                end else begin
                    state_next_s = ST_SET_MINUTES;
                end
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
    end

    // State, time and edge-detect registers; flags decode the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r           <= ST_RUN;
            prescaler_r       <= {PW{1'b0}};
            hours_r           <= 5'd0;
            minutes_r         <= 6'd0;
            seconds_r         <= 6'd0;
            btn_mode_q_r      <= 1'b1;
            btn_inc_q_r       <= 1'b1;
            setting_hours_r   <= 1'b0;
            setting_minutes_r <= 1'b0;
        end else begin
            state_r           <= state_next_s;
            prescaler_r       <= prescaler_next_s;
            hours_r           <= hours_next_s;
            minutes_r         <= minutes_next_s;
            seconds_r         <= seconds_next_s;
            btn_mode_q_r      <= btn_mode;
            btn_inc_q_r       <= btn_inc;
            setting_hours_r   <= (state_next_s == ST_SET_HOURS);
            setting_minutes_r <= (state_next_s == ST_SET_MINUTES);
        end
    end

    assign hours           = hours_r;
    assign minutes         = minutes_r;
    assign seconds         = seconds_r;
    assign setting_hours   = setting_hours_r;
    assign setting_minutes = setting_minutes_r;

`ifdef RTC_BLINK_EN
    localparam int BLINK_TC = (CLK_FREQ_HZ / 4 > 1) ? CLK_FREQ_HZ / 4 : 1;
    localparam int BW       = (BLINK_TC > 1) ? $clog2(BLINK_TC) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TC - 1);

    logic [BW-1:0] blink_cnt_r;
    logic          blink_r;

    // 2 Hz blink while setting; restarted visible after each edit and outside set mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_r <= {BW{1'b0}};
            blink_r     <= 1'b0;
        end else if ((state_next_s == ST_RUN) || inc_rise_s) begin
            blink_cnt_r <= {BW{1'b0}};
            blink_r     <= 1'b0;
        end else if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_r <= {BW{1'b0}};
            blink_r     <= ~blink_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + {{(BW-1){1'b0}}, 1'b1};
            blink_r     <= blink_r;
        end
    end

    assign blink = blink_r;
`else
    assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_time_keeper.sv
// Self-checking bench for rtc_time_keeper: directed set/rollover steps plus random
// button traffic, checked against a seconds-of-day reference model.
module tb_rtc_time_keeper;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       setting_hours;
    logic       setting_minutes;
    logic       blink;

    int errors = 0;
    int checks = 0;

    // Reference model: time of day as one integer, mode 0=RUN 1=SET_H 2=SET_M.
    int tod = 0;
    int md = 0;
    int pre = 0;
    int age = 0;
    bit pm = 1'b1;
    bit pi = 1'b1;

    rtc_time_keeper #(.CLK_FREQ_HZ(8)) dut (
        .clk(clk),
        .reset(reset),
        .btn_mode(btn_mode),
        .btn_inc(btn_inc),
        .hours(hours),
        .minutes(minutes),
        .seconds(seconds),
        .setting_hours(setting_hours),
        .setting_minutes(setting_minutes),
        .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit m, input bit i, input bit r);
        bit mr, ir;
        int h, mi, s;
        if (r) begin
            tod = 0; md = 0; pre = 0; age = 0; pm = 1'b1; pi = 1'b1;
        end else begin
            mr = m && !pm;
            ir = i && !pi;
            pm = m;
            pi = i;
            h  = tod / 3600;
            mi = (tod / 60) % 60;
            s  = tod % 60;
            case (md)
                0: begin
                    if (pre == 7) begin
                        pre = 0;
                        tod = (tod + 1) % 86400;
                    end else begin
                        pre++;
                    end
                    if (mr) md = 1;
                end
                1: begin
                    if (mr) md = 2;
                    else if (ir) tod = ((h + 1) % 24) * 3600 + mi * 60 + s;
                end
                default: begin
                    if (mr) begin
                        md = 0;
                        pre = 0;
                        tod = tod - s;
                    end else if (ir) begin
                        tod = h * 3600 + ((mi + 1) % 60) * 60 + s;
                    end
                end
            endcase
            if (md == 0 || ir) age = 0;
            else age++;
        end
    endtask

    task automatic check_all();
        chk("hours", hours, tod / 3600);
        chk("minutes", minutes, (tod / 60) % 60);
        chk("seconds", seconds, tod % 60);
        chk("setting_hours", setting_hours, (md == 1));
        chk("setting_minutes", setting_minutes, (md == 2));
`ifdef RTC_BLINK_EN
        chk("blink", blink, (age / 2) % 2);
`else
        chk("blink", blink, 0);
`endif
    endtask

    task automatic step(input bit m, input bit i, input bit r);
        btn_mode = m;
        btn_inc  = i;
        reset    = r;
        @(posedge clk);
        model_edge(m, i, r);
        #1;
        check_all();
    endtask

    task automatic press_mode();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_inc(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // 1: reset with mode button held; release with it still held
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("reset_hours", hours, 0);
        chk("reset_seconds", seconds, 0);
        chk("reset_flag", setting_hours, 0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0);
        chk("held_no_mode", setting_hours, 0);
        step(1'b0, 1'b0, 1'b0);

        // 2: preload 23:59:58 then roll over midnight
        press_mode();
        press_inc(23);
        press_mode();
        press_inc(59);
        press_mode();
        chk("set_exit_seconds", seconds, 0);
        idle(58 * 8 - 1);
        chk("pre_h", hours, 23);
        chk("pre_m", minutes, 59);
        chk("pre_s", seconds, 58);
        idle(8);
        chk("s59", seconds, 59);
        idle(8);
        chk("wrap_h", hours, 0);
        chk("wrap_m", minutes, 0);
        chk("wrap_s", seconds, 0);

        // 3: set hours to 3, minutes wrap to 1, exit
        press_mode();
        press_inc(3);
        chk("sh_flag", setting_hours, 1);
        chk("sh_hours", hours, 3);
        press_mode();
        press_inc(61);
        chk("sm_minutes", minutes, 1);
        chk("sm_hours", hours, 3);
        press_mode();
        chk("exit_seconds", seconds, 0);

        // 4: hours wrap in SET_HOURS leaves minutes alone
        press_mode();
        press_inc(20);
        chk("h23", hours, 23);
        press_inc(1);
        chk("h_wrap", hours, 0);
        chk("h_wrap_min", minutes, 1);

        // 5: simultaneous mode and inc edges
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("both_state", setting_minutes, 1);
        chk("both_hours", hours, 0);

        // 6: reset in SET_MINUTES at 12:34
        press_inc(33);
        press_mode();
        press_mode();
        press_inc(12);
        press_mode();
        chk("pre_reset_h", hours, 12);
        chk("pre_reset_m", minutes, 34);
        idle(5);
        step(1'b0, 1'b0, 1'b1);
        chk("mid_reset_h", hours, 0);
        chk("mid_reset_m", minutes, 0);
        chk("mid_reset_flag", setting_minutes, 0);

        // random button traffic with occasional reset
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 11) == 0), $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 799) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
